// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and frame defaults.
// Used by both uart_tx and uart_rx so the two ends agree on timing.
package uart_pkg;

   localparam int OVS         = 16;
   localparam int DEF_DBIT    = 8;
   localparam int DEF_SB_TICK = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side port bundle of the UART transmitter plus the serial line and a state view.
interface uart_tx_if;
   import uart_pkg::*;

   // Request/acknowledge: tx_start acts as valid; it is taken only while tx_busy=0
   // (transmitter idle), tx_din is captured on that same edge, and tx_busy=1 from then
   // on serves as the acknowledge. tx_done pulses once when the frame has left the pin.
   logic        tx_start;
   logic [7:0]  tx_din;
   logic        tx;
   logic        tx_busy;
   logic        tx_done;
   uart_state_e state_dbg;

   modport master (
      output tx_start, tx_din,
      input  tx, tx_busy, tx_done, state_dbg
   );

   modport slave (
      input  tx_start, tx_din,
      output tx, tx_busy, tx_done, state_dbg
   );

endinterface

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter timed by a shared 16x oversampling tick.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
module uart_tx
   import uart_pkg::*;
#(
   parameter int DBIT       = DEF_DBIT,
   parameter int SB_TICK    = DEF_SB_TICK,
   parameter int PARITY_ODD = 0
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     stick,
   uart_tx_if.slave bus
);

   localparam logic [4:0] OVS_LAST  = 5'(OVS - 1);
   localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
   localparam logic [2:0] BIT_LAST  = 3'(DBIT - 1);

   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
      $error("uart_tx: PARITY_ODD must be 0 or 1");
   end
   if (SB_TICK != 16 && SB_TICK != 32) begin : g_bad_sb_tick
      $error("uart_tx: SB_TICK must be 16 or 32");
   end

   uart_state_e state_q, state_d;
   logic [4:0]  s_q, s_d;
   logic [2:0]  n_q, n_d;
   logic [7:0]  b_q, b_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
`ifdef UART_TX_PARITY_EN
   localparam logic PAR_INV = (PARITY_ODD != 0);
   logic        par_q, par_d;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.tx_start) begin
               b_d     = bus.tx_din;
               s_d     = '0;
               busy_d  = 1'b1;
               state_d = ST_START;
`ifdef UART_TX_PARITY_EN
               // Parity is taken from the byte now; the shifter is empty by the time it is sent.
               par_d   = (^bus.tx_din) ^ PAR_INV;
`endif
            end
         end
         ST_START: begin
            if (stick) begin
               if (s_q == OVS_LAST) begin
                  s_d     = '0;
                  n_d     = '0;
                  state_d = ST_DATA;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         ST_DATA: begin
            if (stick) begin
               if (s_q == OVS_LAST) begin
                  s_d = '0;
                  b_d = b_q >> 1;
                  if (n_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end else begin
                     n_d = n_q + 3'd1;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (stick) begin
               if (s_q == OVS_LAST) begin
                  s_d     = '0;
                  state_d = ST_STOP;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
`endif
         ST_STOP: begin
            if (stick) begin
               if (s_q == STOP_LAST) begin
                  s_d     = '0;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The line level is registered, so it is derived from where the FSM is heading.
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_d = par_d;
`endif
         default:   tx_d = 1'b1;
      endcase
   end

   assign bus.tx        = tx_q;
   assign bus.tx_busy   = busy_q;
   assign bus.tx_done   = done_q;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle comparison against a tick-level line model, plus
// hand-computed line samples. Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int SB      = 16;
   localparam int PAR_ODD = 0;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_CLK = 176;
`else
   localparam int FRAME_CLK = 160;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic stick = 1'b0;
   always #5 clk = ~clk;

   uart_tx_if bus ();

   uart_tx #(
      .DBIT       (8),
      .SB_TICK    (SB),
      .PARITY_ODD (PAR_ODD)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .stick (stick),
      .bus   (bus.slave)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int ncyc     = 0;
   int dut_done_cnt = 0;
   int stick_mode = 0;
   int cyc = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
   endfunction

   // ---------------- reference model ----------------
   // exp_q holds the line level for every stick tick still to be sent in the current frame.
   logic [0:0] exp_q[$];
   bit m_busy = 1'b0;
   bit m_done = 1'b0;
   int m_acc_cnt = 0;

   function automatic void m_load(input logic [7:0] b);
      for (int t = 0; t < OVS; t++) exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++)
         for (int t = 0; t < OVS; t++) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
      for (int t = 0; t < OVS; t++) exp_q.push_back((^b) ^ 1'(PAR_ODD));
`endif
      for (int t = 0; t < SB; t++) exp_q.push_back(1'b1);
   endfunction

   // Compare at the falling edge, then apply the inputs the next rising edge will see.
   initial forever begin
      @(negedge clk);
      ncyc++;
      if (!rst) begin
         exp_q.delete();
         m_busy = 1'b0;
         m_done = 1'b0;
      end
      check("tx",         32'(bus.tx),      32'(m_busy ? exp_q[0] : 1'b1));
      check("tx_busy",    32'(bus.tx_busy), 32'(m_busy));
      check("tx_done",    32'(bus.tx_done), 32'(m_done));
      check("idle_state", 32'(bus.state_dbg == ST_IDLE), 32'(!m_busy));
      if (bus.tx_done) dut_done_cnt++;
      if (rst) begin
         m_done = 1'b0;
         if (m_busy) begin
            if (stick) begin
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) begin
                  m_busy = 1'b0;
                  m_done = 1'b1;
               end
            end
         end else if (bus.tx_start) begin
            m_load(bus.tx_din);
            m_busy = 1'b1;
            m_acc_cnt++;
         end
      end
   end

   // ---------------- stick generator ----------------
   initial forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (stick_mode)
         0:       stick = 1'b1;
         1:       stick = ((cyc % 4) == 0);
         default: stick = ($urandom_range(0, 2) == 0);
      endcase
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [7:0] b);
      int c0;
      int n;
      c0 = m_acc_cnt;
      n = 0;
      bus.tx_din   = b;
      bus.tx_start = 1'b1;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (m_acc_cnt == c0 && n < 5000);
      bus.tx_start = 1'b0;
      bus.tx_din   = 8'($urandom);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((m_busy || bus.tx_busy) && n < 6000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 6000) check("idle_timeout", 32'(bus.tx_busy), 32'd0);
   endtask

   // Wait for the falling edge of cycle k after the accepting edge recorded as base.
   task automatic sample_at(input int base, input int k);
      while (ncyc < base + k + 1) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin : watchdog
      #1500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int base;
      int base2;
      int d0;
      logic [8:0] a5_line;
      logic [9:0] f0_line;

      bus.tx_start = 1'b0;
      bus.tx_din   = 8'h00;
      #1 rst = 1'b0;
      idle_cycles(3);
      check("rst_tx",    32'(bus.tx),        32'd1);
      check("rst_busy",  32'(bus.tx_busy),   32'd0);
      check("rst_done",  32'(bus.tx_done),   32'd0);
      check("rst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
      rst = 1'b1;
      idle_cycles(3);

      // Basic frame, stick held high.
      stick_mode = 0;
      idle_cycles(1);
      a5_line = 9'b1_0100_101_0;
      send(8'hA5);
      base = ncyc;
      sample_at(base, 0);
      check("a5_busy_first", 32'(bus.tx_busy), 32'd1);
      for (int i = 0; i < 9; i++) begin
         sample_at(base, 16 * i + 8);
         check("a5_line", 32'(bus.tx), 32'(a5_line[i]));
      end
`ifdef UART_TX_PARITY_EN
      sample_at(base, 152);
      check("a5_parity", 32'(bus.tx), 32'd0);
      sample_at(base, 168);
      check("a5_stop", 32'(bus.tx), 32'd1);
`else
      sample_at(base, 152);
      check("a5_stop", 32'(bus.tx), 32'd1);
`endif
      sample_at(base, FRAME_CLK - 1);
      check("a5_done_early", 32'(bus.tx_done), 32'd0);
      check("a5_busy_last",  32'(bus.tx_busy), 32'd1);
      sample_at(base, FRAME_CLK);
      check("a5_done", 32'(bus.tx_done), 32'd1);
      check("a5_busy_end", 32'(bus.tx_busy), 32'd0);
      wait_idle();

`ifdef UART_TX_PARITY_EN
      send(8'h07);
      base = ncyc;
      sample_at(base, 152);
      check("p07_parity", 32'(bus.tx), 32'd1);
      sample_at(base, 176);
      check("p07_done", 32'(bus.tx_done), 32'd1);
      wait_idle();
`endif

      // Sparse tick: one stick every 4th clock, 64 clocks per bit.
      stick_mode = 1;
      idle_cycles(2);
      f0_line = 10'b1_0000_1111_0;
      send(8'h0F);
      base = ncyc;
      for (int i = 0; i < 9; i++) begin
         sample_at(base, 32 + 64 * i);
         check("sparse_line", 32'(bus.tx), 32'(f0_line[i]));
      end
`ifdef UART_TX_PARITY_EN
      sample_at(base, 32 + 64 * 9);
      check("sparse_parity", 32'(bus.tx), 32'd0);
      sample_at(base, 32 + 64 * 10);
      check("sparse_stop", 32'(bus.tx), 32'd1);
`else
      sample_at(base, 32 + 64 * 9);
      check("sparse_stop", 32'(bus.tx), 32'd1);
`endif
      wait_idle();

      // Back-to-back 0x00, 0xFF, 0x5A with no idle gap.
      stick_mode = 0;
      idle_cycles(2);
      send(8'h00);
      base = ncyc;
      sample_at(base, FRAME_CLK - 1);
      check("b2b_stop", 32'(bus.tx), 32'd1);
      @(posedge clk);
      #1;
      send(8'hFF);
      base2 = ncyc;
      sample_at(base2, 0);
      check("b2b_start", 32'(bus.tx), 32'd0);
      check("b2b_busy",  32'(bus.tx_busy), 32'd1);
      @(posedge clk);
      #1;
      send(8'h5A);
      wait_idle();

      // tx_start during a frame is ignored.
      idle_cycles(3);
      d0 = dut_done_cnt;
      send(8'hC3);
      idle_cycles(50);
      bus.tx_din   = 8'h11;
      bus.tx_start = 1'b1;
      idle_cycles(1);
      bus.tx_start = 1'b0;
      idle_cycles(400);
      check("ignored_start_frames", 32'(dut_done_cnt - d0), 32'd1);
      check("ignored_start_idle",   32'(bus.tx_busy),       32'd0);

      // Reset mid-frame returns the line high without a clock edge.
      send(8'h00);
      idle_cycles(39);
      #2 rst = 1'b0;
      #1;
      check("midrst_tx",    32'(bus.tx),        32'd1);
      check("midrst_busy",  32'(bus.tx_busy),   32'd0);
      check("midrst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
      idle_cycles(3);
      rst = 1'b1;
      idle_cycles(2);
      send(8'h3C);
      wait_idle();

      // Randomized bytes, tick patterns and gaps.
      for (int i = 0; i < 16; i++) begin
         stick_mode = $urandom_range(0, 2);
         send(8'($urandom));
         if ($urandom_range(0, 1) == 1) wait_idle();
         idle_cycles($urandom_range(0, 5));
      end
      wait_idle();
      idle_cycles(4);
      check("end_idle_state", 32'(bus.state_dbg), 32'(ST_IDLE));
      check("end_line_high",  32'(bus.tx),        32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

8-bit UART transmitter, the counterpart of `uart_rx`: accepts a byte on a start strobe and serialises it onto `tx` as start bit, 8 data bits LSB-first, optional parity and 1 or 2 stop bits. Bit timing uses the same 16x oversampling tick `stick` that drives the receiver, so a shared baud generator feeds both ends. The block sits between the host-side byte source and the serial pin.

## Interface
Parameters:
- `DBIT`, 8: data bits per frame; fixed at 8 for this release.
- `SB_TICK`, 16: `stick` pulses per stop bit; 16 = 1 stop bit, 32 = 2 stop bits.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity; used only when `UART_TX_PARITY_EN` is defined.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `stick` input 1: oversampling tick, one `clk` cycle wide, 16 per bit period; may be held high (every cycle is a tick).
- `tx_start` input 1: request to send `tx_din`; sampled only in IDLE.
- `tx_din` input 8: byte to send; captured on the accepting edge.
- `tx` output 1: serial line, idle high.
- `tx_busy` output 1: high from the accepting edge until the frame ends.
- `tx_done` output 1: one-`clk` pulse at the end of the final stop tick.

## Operation
- Reset (`rst`=0, asynchronous): state IDLE, `tx`=1, `tx_busy`=0, `tx_done`=0, tick and bit counters 0, shift register 0. Reset mid-frame aborts the frame immediately; the line returns high without waiting for a clock edge.
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: `tx`=1. When `tx_start`=1 on an edge: capture `tx_din` into the shift register, clear the tick counter, set `tx_busy`=1, go to START.
- START: `tx`=0. Count `stick` pulses. On the 16th tick (counter=15 with `stick`=1): clear the counter, clear the bit counter, go to DATA.
- DATA: `tx`=shift[0]. On the 16th tick: shift right by 1. If the bit counter equals DBIT-1, go to PARITY (macro) or STOP; otherwise increment the bit counter.
- PARITY: `tx`=XOR of the captured byte, inverted when PARITY_ODD=1. After 16 ticks, go to STOP.
- STOP: `tx`=1. On tick SB_TICK (counter=SB_TICK-1 with `stick`=1): pulse `tx_done`, clear `tx_busy`, return to IDLE.
- The tick counter advances only on cycles with `stick`=1. `tx_start` is ignored while busy, and `tx_din` changes while busy have no effect.
- The tick counter is 5 bits wide to cover SB_TICK=32. The bit counter is 3 bits wide.

## Timing
- `tx` is registered. The start bit appears on `tx` in the cycle after the accepting edge.
- With `stick` held high: start bit 16 clk, each data bit 16 clk, parity 16 clk, stop SB_TICK clk.
- Frame length with stick=1, 1 stop bit, no parity: 160 clk from the accepting edge to the `tx_done` edge.
- `tx_done` and `tx_busy`=0 take effect on the same edge. The earliest next accept is the following edge, so back-to-back frames have zero idle gap beyond the stop bit(s).
- `tx_start` coincident with `tx_done` is ignored. The state is not yet IDLE on that edge.
- A `stick` pulse on the accepting edge is not counted.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: the PARITY state is compiled in and one parity bit is inserted between the data bits and the stop bits. Frame = 11 bit periods with 1 stop bit.
  - Undefined: the PARITY state and its logic are absent, `PARITY_ODD` is unused, and the frame is 10 bit periods.

## Structure
- Shared package `uart_pkg`: state encoding constants (IDLE/START/DATA/PARITY/STOP), OVS=16 oversampling constant, default DBIT/SB_TICK values. `uart_rx` uses the same package.
- A single flat module. The tick/bit counting is small enough that no sub-module is needed. The baud tick generator lives outside and is shared with `uart_rx`.

## Test plan
- Reset mid-frame:
  - Stimulus: send 0x00, assert `rst`=0 at clk 40.
  - Required response: `tx`=1 and `tx_busy`=0 immediately.
  - After release: a new `tx_start` with 0x3C produces a correct full frame.
- Basic frame:
  - Stimulus: stick=1, `tx_din`=0xA5, one-cycle `tx_start`.
  - Required response: `tx` low 16 clk, then bits 1,0,1,0,0,1,0,1 at 16 clk each, then high 16 clk. `tx_done` pulses 160 clk after acceptance; `tx_busy` is high throughout.
- Sparse tick:
  - Stimulus: `stick` pulses every 4th clk, `tx_din`=0x0F.
  - Required response: each bit lasts 64 clk. The line pattern is 0, 1,1,1,1,0,0,0,0, 1.
- Loopback:
  - Stimulus: connect `tx` to `uart_rx.rx` with shared `stick`, send 0x00, 0xFF, 0x5A back-to-back.
  - Required response: receiver `rx_dout` matches each byte with one `done` per frame, and there is no idle gap between frames.
- Ignored start:
  - Stimulus: pulse `tx_start` with 0x11 at clk 50 during a 0xC3 frame.
  - Required response: the 0xC3 frame is unaltered and no second frame is sent.
- Parity (macro defined):
  - Stimulus: PARITY_ODD=0, `tx_din`=0x07.
  - Required response: parity bit=1 and the frame is 176 clk long.
  - With PARITY_ODD=1: parity bit=0.
